rr_grant_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource between N requesters.
- Issues a one-hot grant, equivalent to a decoded grant index, the same function as the team's 1-to-N decoders.
- Holds each grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits in front of any shared datapath unit, e.g. a memory port or bus master slot.

---
 rtl/rr_grant_arbiter_if.sv | 24 ++
 rtl/rr_grant_arbiter.sv | 119 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The arbiter uses the slave side; requesters (or a bench) drive the master side.
interface rr_grant_arbiter_if #(
  parameter int N = 4
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds until done, request
// drop or MAX_HOLD cycles, then always spends one idle cycle before re-arbitrating.
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  localparam int IW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  rr_grant_arbiter_if.slave  bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0]    state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [7:0]    hold_cnt_reg, hold_cnt_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [IW-1:0] gnt_idx_reg, gnt_idx_next;
  logic          gnt_valid_reg, gnt_valid_next;
  logic          timeout_reg, timeout_next;

  // First requester at or after ptr, wrapping modulo N.
  logic          found;
  logic [IW-1:0] pick;
  int            cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_reg) + k) % N;
      if (!found && bus.req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  logic [N-1:0] pick_onehot;

  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign pick_onehot[gi] = (pick == IW'(gi));
  end

  logic          owner_release;
  logic          forced_release;

  assign owner_release  = bus.done || !bus.req[gnt_idx_reg];
  assign forced_release = !owner_release && (hold_cnt_reg == HOLD_LAST);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    gnt_next       = gnt_reg;
    gnt_idx_next   = gnt_idx_reg;
    gnt_valid_next = gnt_valid_reg;
    timeout_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next     = GRANT;
          gnt_next       = pick_onehot;
          gnt_idx_next   = pick;
          gnt_valid_next = 1'b1;
          hold_cnt_next  = '0;
          ptr_next       = (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
        end
      end
      GRANT: begin
        if (owner_release || forced_release) begin
          state_next     = IDLE;
          gnt_next       = '0;
          gnt_idx_next   = '0;
          gnt_valid_next = 1'b0;
          hold_cnt_next  = '0;
          timeout_next   = forced_release;
        end else begin
          hold_cnt_next  = hold_cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_next       = '0;
        gnt_idx_next   = '0;
        gnt_valid_next = 1'b0;
        hold_cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      hold_cnt_reg  <= '0;
      gnt_reg       <= '0;
      gnt_idx_reg   <= '0;
      gnt_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      gnt_reg       <= gnt_next;
      gnt_idx_reg   <= gnt_idx_next;
      gnt_valid_reg <= gnt_valid_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.gnt_idx   = gnt_idx_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: owner/ptr/held-cycles reference model checked every
// negedge, plus directed scenarios with literal expectations and random traffic.
module tb_rr_grant_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_grant_arbiter_if #(.N(N)) bus ();

  rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, how long it has held it,
  // where the next search starts, and whether the last release was forced.
  int m_owner   = -1;
  int m_held    = 0;
  int m_ptr     = 0;
  bit m_timeout = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner   = -1;
      m_held    = 0;
      m_ptr     = 0;
      m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && bus.req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            m_held  = 1;
            m_ptr   = (m_owner + 1) % N;
          end
        end
      end else if (bus.done || !bus.req[m_owner]) begin
        m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        m_owner   = -1;
        m_timeout = 1'b1;
      end else begin
        m_held++;
      end
    end
  end

  logic [N-1:0] exp_gnt;

  always @(negedge clk) begin
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    check("gnt",       int'(bus.gnt),       int'(exp_gnt));
    check("gnt_idx",   int'(bus.gnt_idx),   (m_owner >= 0) ? m_owner : 0);
    check("gnt_valid", int'(bus.gnt_valid), (m_owner >= 0) ? 1 : 0);
    check("timeout",   int'(bus.timeout),   int'(m_timeout));
    check("onehot",    int'($countones(bus.gnt) <= 1), 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; outputs must clear while rst is still high.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt",       int'(bus.gnt), 0);
    check("rst_gnt_valid", int'(bus.gnt_valid), 0);
    check("rst_timeout",   int'(bus.timeout), 0);
    #1;
    rst = 1'b0;
  endtask

  int order [5] = '{1, 2, 4, 8, 1};
  int held_cycles;
  bit dropped;

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;
    tick();
    do_reset();

    // Single requester, done release, then ptr=3 shows as priority to requester 3.
    bus.req = 4'b0100;
    tick(); check("t2_gnt", int'(bus.gnt), 4'b0100); check("t2_idx", int'(bus.gnt_idx), 2);
    tick(); tick(); check("t2_hold", int'(bus.gnt), 4'b0100);
    bus.done = 1'b1;
    tick(); check("t2_rel", int'(bus.gnt), 0); check("t2_to", int'(bus.timeout), 0);
    bus.done = 1'b0;
    bus.req  = 4'b1111;
    tick(); check("t2_ptr3", int'(bus.gnt), 4'b1000);
    bus.req = '0;
    tick(); tick();

    // Wrap: ptr=3 with req=0011 picks 0 first, then 1.
    bus.req = 4'b0100;
    tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0011;
    tick(); check("t4_wrap", int'(bus.gnt), 4'b0001); check("t4_idx", int'(bus.gnt_idx), 0);
    bus.done = 1'b1;
    tick(); check("t4_idle", int'(bus.gnt), 0);
    bus.done = 1'b0;
    tick(); check("t4_next", int'(bus.gnt), 4'b0010);
    bus.done = 1'b1;
    bus.req  = '0;
    tick();
    bus.done = 1'b0;
    tick();

    // Owner drop: switch req from 0010 to 1000.
    do_reset();
    bus.req = 4'b0010;
    tick(); check("t6_gnt", int'(bus.gnt), 4'b0010);
    bus.req = 4'b1000;
    tick(); check("t6_rel", int'(bus.gnt), 0); check("t6_to", int'(bus.timeout), 0);
    tick(); check("t6_new", int'(bus.gnt), 4'b1000);
    bus.req = '0;
    tick(); tick();

    // Rotation with all requesting, done pulsed after each grant.
    do_reset();
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick(); check("t3_order", int'(bus.gnt), order[j]);
      bus.done = 1'b1;
      tick(); check("t3_idle", int'(bus.gnt), 0);
      bus.done = 1'b0;
    end
    bus.req = '0;
    tick(); tick();

    // Forced release after exactly MAX_HOLD cycles, then immediate re-grant.
    do_reset();
    bus.req     = 4'b0001;
    held_cycles = 0;
    dropped     = 1'b0;
    for (int c = 0; c < 3 * MAX_HOLD && !dropped; c++) begin
      tick();
      if (bus.gnt == 4'b0001) held_cycles++;
      else if (held_cycles > 0) dropped = 1'b1;
    end
    check("t5_held", held_cycles, MAX_HOLD);
    check("t5_to", int'(bus.timeout), 1);
    tick(); check("t5_regnt", int'(bus.gnt), 4'b0001); check("t5_to_clr", int'(bus.timeout), 0);
    bus.req = '0;
    tick(); tick();

    // Asynchronous reset mid-grant, then ptr is back at 0.
    do_reset();
    bus.req = 4'b0100;
    tick(); check("t1_pre", int'(bus.gnt), 4'b0100);
    do_reset();
    bus.req = 4'b1111;
    tick(); check("t1_post", int'(bus.gnt), 4'b0001);
    bus.req = '0;
    tick(); tick();

    // Random traffic; requests change rarely so timeouts and drops both occur.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req = N'($urandom_range(0, (1 << N) - 1));
      bus.done = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end
    bus.req  = '0;
    bus.done = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
